// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over one memory port, ALU and register file.
`timescale 1ns/1ps
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    illegal    = 1'b0;

    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase

    unique case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BR:        state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        state_d = ALUWB;
        // addi never subtracts, whatever imm[10] happens to be
        case (funct3)
          3'b000:  ALUControl = (state_q == EXECUTER && funct7b5)
                                ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: state_d = TRAP;
        endcase
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        state_d    = FETCH;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = !Zero;
          default: state_d = TRAP;
        endcase
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      TRAP: illegal = 1'b1;
      default: state_d = FETCH;
    endcase

    if (rst) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = 2'b00;
      illegal    = 1'b0;
    end
  end

  // Every terminal state returns to FETCH; TRAP and FETCH itself never do.
  assign retire  = (state_q != FETCH) && (state_d == FETCH);
  assign instret = instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core variant. It sequences instruction fetch, register read, execute, memory access and writeback over a single shared memory port, ALU and register file. It consumes the opcode and function fields produced by the instruction decoder and drives every datapath select and write strobe. It also stalls on a memory ready handshake, traps on unsupported encodings and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  single core clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  decoded opcode, taken from the held instruction register
- funct3  in  3  decoded funct3
- funct7b5  in  1  bit 5 of funct7
- Zero  in  1  ALU zero flag for the current cycle
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request valid
- MemWrite  out  1  request is a store
- AdrSrc  out  1  memory address source: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load the instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write
- ResultSrc  out  2  Result mux: 00 = ALUOut, 01 = read data, 10 = ALUResult
- ALUSrcA  out  2  ALU A source: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B source: 00 = rs2, 01 = imm, 10 = constant 4
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- illegal  out  1  sticky trap flag
- instret  out  32  count of retired instructions

## Operation
- **Reset.** While rst is high, state is FETCH, instret = 0 and illegal = 0. All strobes (mem_req, MemWrite, IRWrite, PCWrite, RegWrite) are forced to 0. All mux selects are 0.
- **Output defaults.** Outputs are combinational from state. Any field not listed for a state is 0.
- **ImmSrc** is decoded from op in every state:
  - lw and I-ALU: 00
  - sw: 01
  - branch: 10
  - jal: 11
  - any other op: 00
- **ALUControl in EXECUTER / EXECUTEI.** funct3 000 gives add, except R-type with funct7b5 = 1, which gives sub. funct3 010 gives slt. funct3 110 gives or. funct3 111 gives and. Any other funct3 goes to TRAP instead of ALUWB.
- **FETCH.** Outputs: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
  - IRWrite and PCWrite are asserted only when mem_ready is 1 (Mealy).
  - If mem_ready = 0, stay in FETCH.
  - If mem_ready = 1, go to DECODE.
- **DECODE.** Outputs: ALUSrcA = 01, ALUSrcB = 01, add (branch/jump target into ALUOut). Next state by op:
  - 0000011 (lw) or 0100011 (sw): MEMADR
  - 0110011 (R-type): EXECUTER
  - 0010011 (I-ALU): EXECUTEI
  - 1100011 (branch): BRANCH
  - 1101111 (jal): JAL
  - any other op: TRAP
- **MEMADR.** Outputs: ALUSrcA = 10, ALUSrcB = 01, add. Go to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD.** Outputs: mem_req = 1, AdrSrc = 1. Wait for mem_ready, then go to MEMWB.
- **MEMWB.** Outputs: ResultSrc = 01, RegWrite = 1. Go to FETCH.
- **MEMWRITE.** Outputs: mem_req = 1, MemWrite = 1, AdrSrc = 1. Wait for mem_ready, then go to FETCH.
- **EXECUTER.** Outputs: ALUSrcA = 10, ALUSrcB = 00. Go to ALUWB.
- **EXECUTEI.** Outputs: ALUSrcA = 10, ALUSrcB = 01. Go to ALUWB.
- **ALUWB.** Outputs: ResultSrc = 00, RegWrite = 1. Go to FETCH.
- **BRANCH.** Outputs: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00.
  - funct3 000 (beq): PCWrite = Zero.
  - funct3 001 (bne): PCWrite = !Zero.
  - Any other funct3: go to TRAP with PCWrite = 0.
  - Otherwise go to FETCH.
- **JAL.** Outputs: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1. Go to ALUWB.
- **TRAP.** illegal = 1 and all strobes are 0. The FSM stays in TRAP until reset.
- **Retire counting.** instret increments by 1 on each clock edge that leaves a terminal state toward FETCH:
  - MEMWB
  - MEMWRITE with mem_ready = 1
  - ALUWB
  - BRANCH
  - instret wraps from 0xFFFFFFFF to 0.
  - JAL is counted on its ALUWB exit, so it counts once.
  - TRAP never increments.

## Timing
- Each non-waiting state lasts exactly 1 cycle.
- Memory states (FETCH, MEMREAD, MEMWRITE) last 1 + N cycles, where N is the number of cycles with mem_ready low.
- Latency with zero-wait memory:
  - lw: 5 cycles
  - sw, R-type, I-ALU, jal: 4 cycles
  - branch: 3 cycles
- mem_req stays high and AdrSrc stays stable for the whole of every wait. MemWrite is high for every cycle of MEMWRITE.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- A reset asserted mid-instruction, including mid-wait, returns the FSM to FETCH asynchronously. Strobes drop in the same cycle, and no partial write is issued after reset.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready always 1 -> states FETCH, DECODE, EXECUTER, ALUWB; ALUControl = 000; RegWrite high in cycle 4; instret 0 -> 1.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMREAD -> 10 cycles total; IRWrite pulses exactly once; RegWrite with ResultSrc = 01 in the final cycle.
- beq with Zero = 1, then beq with Zero = 0, then bne with Zero = 0 -> PCWrite in BRANCH is 1, 0, 1 respectively; each instruction takes 3 cycles.
- op = 1110011 -> TRAP after DECODE; illegal = 1; no strobes for 20 cycles; instret unchanged; rst pulse clears illegal and restarts in FETCH.
- rst asserted in MEMWRITE wait -> MemWrite = 0 immediately; after release, FETCH with mem_req = 1.
- instret preloaded by running 2^32 − 1 retirements (or via forced state), then one more I-ALU instruction -> instret = 0.
